// File: rtl/f_pkg.sv
// Shared constants for the fetch next-PC block: widths, BTB entry layout
// and FSM state encoding.
package f_pkg;
  localparam int PC_W      = 13;
  localparam int IDX_W     = 11;
  localparam int VALID_BIT = 15;
  localparam int TAG_HI    = 14;
  localparam int TAG_LO    = 13;
  localparam int TGT_HI    = 12;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/btb_ram.sv
// BTB storage: one synchronous write port, one synchronous read port.
// It has no reset, so it can map onto block RAM.
module btb_ram #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [1<<AW];

  // A read of the slot being written returns the old data; the caller bypasses.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/f_predpc.sv
// Fetch-stage next-PC generator: holds the fetch PC, looks up the BTB for a
// predicted successor and clears the BTB with a full sweep after reset.
module f_predpc
  import f_pkg::VALID_BIT, f_pkg::TAG_HI, f_pkg::TAG_LO, f_pkg::TGT_HI,
         f_pkg::ST_INIT, f_pkg::ST_RUN;
#(
  parameter int PC_W = 13,
  parameter int IDX_W = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             fail_predict,
  input  logic [PC_W-1:0]  true_pc,
  input  logic [15:0]      w_data,
  input  logic [IDX_W-1:0] w_addr,
  input  logic             wen,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_predicted,
  output logic             pc_valid,
  output logic [0:0]       o_state
);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [PC_W-1:0]  r_pc;
  logic             r_byp;
  logic [15:0]      r_byp_data;

  logic             w_init;
  logic             w_hit;
  logic [15:0]      w_ram_q;
  logic [15:0]      w_entry;
  logic [PC_W-1:0]  w_inc;
  logic [PC_W-1:0]  w_next_pc;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [IDX_W-1:0] w_raddr;
  logic [15:0]      w_wdata;

  assign w_init  = (r_state == ST_INIT);
  assign w_entry = r_byp ? r_byp_data : w_ram_q;
  assign w_inc   = r_pc + PC_ONE;
  assign w_hit   = !w_init && w_entry[VALID_BIT] &&
                   (w_entry[TAG_HI:TAG_LO] == r_pc[PC_W-1:IDX_W]);

  assign pc_predicted = w_hit ? w_entry[TGT_HI:0] : w_inc;
  assign pc           = r_pc;
  assign pc_valid     = !w_init;
  assign o_state      = r_state;

  always_comb begin
    w_next_pc = r_pc;
    if (!w_init) begin
      if (fail_predict)  w_next_pc = true_pc;
      else if (!stall)   w_next_pc = pc_predicted;
    end
  end

  // The sweep owns the write port while clearing; execute-stage writes are dropped.
  always_comb begin
    w_we    = rst_n && (w_init || wen);
    w_waddr = w_init ? r_cnt : w_addr;
    w_wdata = w_init ? 16'h0000 : w_data;
    w_raddr = w_next_pc[IDX_W-1:0];
  end

  btb_ram #(.AW(IDX_W), .DW(16)) u_btb (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_pc       <= RESET_PC;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_pc       <= w_next_pc;
      // Same-slot write and read: present the fresh entry instead of the stale RAM word.
      r_byp      <= w_we && (w_waddr == w_raddr);
      r_byp_data <= w_wdata;
      if (w_init) begin
        r_cnt <= r_cnt + IDX_ONE;
        if (r_cnt == IDX_LAST) r_state <= ST_RUN;
      end
    end
  end
endmodule

// File: tb/tb_f_predpc.sv
// Bench for f_predpc: reference model plus a directed vector table, with all
// expected outputs routed through a scoreboard queue.
module tb_f_predpc;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        fail_predict;
  logic [12:0] true_pc;
  logic [15:0] w_data;
  logic [10:0] w_addr;
  logic        wen;
  logic [12:0] pc;
  logic [12:0] pc_predicted;
  logic        pc_valid;
  logic [0:0]  o_state;

  f_predpc dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fail_predict(fail_predict),
    .true_pc(true_pc), .w_data(w_data), .w_addr(w_addr), .wen(wen),
    .pc(pc), .pc_predicted(pc_predicted), .pc_valid(pc_valid), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record layout {pc_valid, pc, pc_predicted}
  logic [26:0] exp_q[$];
  int total = 0;
  int bad = 0;

  logic [15:0] m_btb [2048];
  logic [12:0] m_pc;
  int          m_init_left;

  typedef struct {
    logic        s;
    logic        f;
    logic [12:0] tpc;
    logic        we;
    logic [10:0] wa;
    logic [15:0] wd;
    logic [12:0] epc;
    logic [12:0] epred;
  } vec_t;
  vec_t vecs[20];

  function automatic logic [12:0] m_pred(input logic [12:0] p);
    logic [15:0] e;
    e = m_btb[p[10:0]];
    if (e[15] && (e[14:13] == p[12:11])) return e[12:0];
    return p + 13'd1;
  endfunction

  task automatic check_out(input string nm);
    logic [26:0] e;
    logic [26:0] got;
    e = exp_q.pop_front();
    got = {pc_valid, pc, pc_predicted};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got valid=%b pc=%h pred=%h, want valid=%b pc=%h pred=%h",
               nm, got[26], got[25:13], got[12:0], e[26], e[25:13], e[12:0]);
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0; stall = 1'b0; fail_predict = 1'b0; true_pc = '0;
    wen = 1'b0; w_addr = '0; w_data = '0;
    for (int i = 0; i < 2048; i++) m_btb[i] = 16'h0000;
    m_pc = 13'd0;
    m_init_left = 2048;
    exp_q.push_back({1'b0, 13'd0, 13'd1});
    @(posedge clk);
    @(negedge clk);
    check_out(nm);
    rst_n = 1'b1;
  endtask

  // Drive one cycle at the negedge; expected comes from the model or the table.
  task automatic step(input string nm, input logic s, input logic f,
                      input logic [12:0] tp, input logic we, input logic [10:0] wa,
                      input logic [15:0] wd, input logic use_tab,
                      input logic [12:0] tpc, input logic [12:0] tpred);
    logic [12:0] nxt;
    logic        v;
    stall = s; fail_predict = f; true_pc = tp; wen = we; w_addr = wa; w_data = wd;
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      nxt = f ? tp : (s ? m_pc : m_pred(m_pc));
      if (we) m_btb[wa] = wd;
      m_pc = nxt;
    end
    v = (m_init_left == 0);
    if (use_tab) exp_q.push_back({1'b1, tpc, tpred});
    else exp_q.push_back({v, m_pc, v ? m_pred(m_pc) : m_pc + 13'd1});
    @(posedge clk);
    @(negedge clk);
    check_out(nm);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 13'h0003, 1'b1, 11'h005, 16'h8100, 13'h0003, 13'h0004};
    vecs[1]  = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0004, 13'h0005};
    vecs[2]  = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0005, 13'h0100};
    vecs[3]  = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0100, 13'h0101};
    vecs[4]  = '{1'b0, 1'b1, 13'h0805, 1'b0, 11'h000, 16'h0000, 13'h0805, 13'h0806};
    vecs[5]  = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0806, 13'h0807};
    vecs[6]  = '{1'b1, 1'b1, 13'h0040, 1'b0, 11'h000, 16'h0000, 13'h0040, 13'h0041};
    vecs[7]  = '{1'b1, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0040, 13'h0041};
    vecs[8]  = '{1'b1, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0040, 13'h0041};
    vecs[9]  = '{1'b1, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0040, 13'h0041};
    vecs[10] = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0041, 13'h0042};
    vecs[11] = '{1'b0, 1'b1, 13'h0010, 1'b1, 11'h010, 16'h8020, 13'h0010, 13'h0020};
    vecs[12] = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0020, 13'h0021};
    vecs[13] = '{1'b1, 1'b0, 13'h0000, 1'b1, 11'h020, 16'h81FF, 13'h0020, 13'h01FF};
    vecs[14] = '{1'b0, 1'b1, 13'h1005, 1'b0, 11'h000, 16'h0000, 13'h1005, 13'h1006};
    vecs[15] = '{1'b0, 1'b0, 13'h0000, 1'b1, 11'h006, 16'hC0AA, 13'h1006, 13'h00AA};
    vecs[16] = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h00AA, 13'h00AB};
    vecs[17] = '{1'b0, 1'b0, 13'h0000, 1'b1, 11'h0AB, 16'h0055, 13'h00AB, 13'h00AC};
    vecs[18] = '{1'b0, 1'b1, 13'h1FFF, 1'b0, 11'h000, 16'h0000, 13'h1FFF, 13'h0000};
    vecs[19] = '{1'b0, 1'b0, 13'h0000, 1'b0, 11'h000, 16'h0000, 13'h0000, 13'h0001};

    do_reset("reset_state");

    // INIT with noise on every input: all of it must be ignored.
    for (int i = 0; i < 2048; i++)
      step("init_sweep", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           13'($urandom), 1'b1, 11'($urandom_range(0, 63)),
           {1'b1, 2'b00, 13'($urandom_range(0, 8191))}, 1'b0, '0, '0);

    // Free-running fetch across the full PC space, including the wrap.
    for (int i = 0; i < 8195; i++)
      step("sequential", 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);

    for (int i = 0; i < 20; i++)
      step($sformatf("vec%0d", i), vecs[i].s, vecs[i].f, vecs[i].tpc, vecs[i].we,
           vecs[i].wa, vecs[i].wd, 1'b1, vecs[i].epc, vecs[i].epred);

    // Random mix confined to a few BTB slots so hits, tags and bypasses recur.
    for (int i = 0; i < 400; i++)
      step("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           {2'($urandom_range(0, 3)), 7'd0, 4'($urandom_range(0, 15))},
           ($urandom_range(0, 1) == 1), 11'($urandom_range(0, 15)),
           {1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 7'd0, 4'($urandom_range(0, 15))},
           1'b0, '0, '0);

    // Populate low slots with tag-0 hits, then reset mid-run: all must miss after the sweep.
    for (int i = 0; i < 16; i++)
      step("prefill", 1'b1, 1'b0, '0, 1'b1, 11'(i), {1'b1, 2'b00, 13'h0700}, 1'b0, '0, '0);
    do_reset("midrun_reset");
    for (int i = 0; i < 2048; i++)
      step("reinit", 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 24; i++)
      step("post_reset_miss", 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/f_predpc.md
# f_predpc

Fetch-stage next-PC generator with a 2048-entry branch target buffer (BTB). It holds the fetch PC and supplies `pc_predicted` for every fetched instruction. That value travels down the pipe to the execute-stage PC check. The block consumes the execute stage's BTB write port (`w_data`/`w_addr`/`wen`) and its redirect (`fail_predict`/`true_pc`). It owns the BTB storage and clears the BTB after reset.

## Interface
- `PC_W`, 13, word-address PC width
- `IDX_W`, 11, BTB index width (2^IDX_W entries)
- `RESET_PC`, 13'd0, fetch PC after reset
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `stall`  in  1  fetch hold request from downstream
- `fail_predict`  in  1  execute-stage misprediction redirect
- `true_pc`  in  13  redirect target, valid with `fail_predict`
- `w_data`  in  16  BTB entry {valid[15], tag[14:13]=pc[12:11], target[12:0]}
- `w_addr`  in  11  BTB index = pc[10:0] of the writing branch
- `wen`  in  1  BTB write strobe
- `pc`  out  13  current fetch PC
- `pc_predicted`  out  13  predicted PC of the instruction after `pc`
- `pc_valid`  out  1  `pc`/`pc_predicted` meaningful (low during INIT)

## Operation
- FSM states:
  - INIT: sweeps the BTB, writing 16'h0000 at index `cnt`, `cnt` 0→2047, one entry per cycle.
  - RUN: entered the cycle after the write at `cnt`=2047.
  - RUN→INIT only by reset.
- During INIT:
  - `wen` is ignored.
  - `fail_predict` and `stall` are ignored.
  - `pc` is held at RESET_PC.
  - `pc_valid`=0.
- Lookup:
  - The read index is `next_pc[10:0]`, so the entry for `pc` is at the RAM output while `pc` is held.
  - hit = entry[15] & (entry[14:13]==pc[12:11]).
  - `pc_predicted` = hit ? entry[12:0] : pc+1. The increment wraps modulo 2^13 (8191→0).
  - Hit is forced to 0 in INIT.
- Next-PC priority:
  - In INIT: next_pc = pc.
  - Else if `fail_predict`: next_pc = `true_pc`. This beats `stall`.
  - Else if `stall`: next_pc = pc.
  - Else: next_pc = `pc_predicted`.
- Write/read collision:
  - Condition: a write (RUN `wen`, or an INIT sweep write) whose index equals the read index in the same cycle.
  - The written data is registered and replaces the RAM output for the next cycle, so the new entry is seen.
  - This also covers `fail_predict` and `wen` together where `true_pc` indexes the written slot.
- `wen` without `fail_predict` only updates storage. It never alters `pc`.
- Synchronous reset mid-RUN: discards the in-flight PC and re-enters INIT with a full 2048-cycle sweep.

## Timing
- Reset values: `pc`=RESET_PC, `pc_valid`=0, FSM=INIT, `cnt`=0, bypass flag=0.
  - `pc_predicted` = RESET_PC+1 (forced miss).
- `pc_valid` rises exactly 2048 cycles after the first clock edge with `rst_n` high, together with `pc`=RESET_PC.
- Redirect latency is 1 cycle. With `fail_predict` at edge t, `pc`=`true_pc` after t, and its prediction is valid in the same cycle.
- BTB write-to-use is 1 cycle. A write at edge t affects `pc_predicted` for any `pc` present after t.
- `stall` holds `pc` and `pc_predicted` stable, unless a write to the held index lands. In that case `pc_predicted` may change the next cycle.
- `pc_predicted` is combinational from the RAM output register and `pc`. No other output is combinational from inputs.

## Structure
- Shared package `f_pkg`:
  - PC_W, IDX_W
  - BTB field positions (VALID_BIT=15, TAG_HI=14, TAG_LO=13, TGT_HI=12)
  - state encoding (ST_INIT, ST_RUN)
- Sub-module `btb_ram`:
  - 2^IDX_W x 16, one synchronous write port, one synchronous read port.
  - No reset, so it maps to block RAM.
  - Bypass, FSM and PC logic stay in `f_predpc`.

## Test plan
- Reset release, no activity → `pc_valid`=0 for 2048 cycles, then `pc`=0, `pc_predicted`=1, then sequential 2, 3…; after 8191, wraps to 0.
- Write at `w_addr`=0x005 with `w_data`={1,2'b00,13'h0100}, fetch reaches pc=5 → `pc_predicted`=0x100, next `pc`=0x100.
- Same entry with tag mismatch, pc=0x805 → miss, `pc_predicted`=0x806.
- `fail_predict`=1, `true_pc`=0x040, with `stall`=1 → next cycle `pc`=0x040 (redirect beats stall); `stall` alone holds `pc` for 3 cycles.
- Same-cycle `fail_predict` (`true_pc`=0x010) and `wen` (`w_addr`=0x010, target 0x020) → `pc`=0x010 with `pc_predicted`=0x020 (bypass).
- Reset asserted mid-RUN after BTB entries are written → full INIT again, and all prior entries miss afterwards.
